bin_to_gray_counter: RTL and testbench
======================================

Name: bin_to_gray_counter

Overview:
- Binary-to-Gray encoder built around a loadable up/down binary counter; it produces Gray-coded values for the existing Gray-to-binary decode path and for the board test setup.
- A binary value can be loaded or stepped, and the block emits the Gray code of the counter through a registered output stage.
- The block supplies Gray stimulus so that loop-back through the decoder returns the original binary value.

Parameters:
WIDTH, 4, bit width of the counter, load value and Gray output (legal range 2..16)

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
bin_in  input  WIDTH  binary value captured into the counter when load=1
load  input  1  load request, sampled on rising clk
cnt_en  input  1  count-step request, sampled on rising clk
up  input  1  count direction: 1 = increment, 0 = decrement
gray_out  output  WIDTH  registered Gray code of the counter
bin_out  output  WIDTH  registered binary counter value, aligned with gray_out
out_valid  output  1  high once gray_out/bin_out hold post-reset data
tc  output  1  one-cycle terminal-count pulse, aligned with the wrapped gray_out value

Behaviour:
- Reset (rst=1, asynchronous, any time): internal counter cnt=0, gray_out=0, bin_out=0, tc=0, out_valid=0. All outputs hold these values while rst is high. Mid-operation reset discards any pending step or load.
- Stage 1 (counter update) at each rising clk with rst=0:
  - load=1: cnt <= bin_in. Load has priority over cnt_en; a simultaneous step is dropped.
  - load=0, cnt_en=1, up=1: cnt <= cnt+1 modulo 2^WIDTH.
  - load=0, cnt_en=1, up=0: cnt <= cnt-1 modulo 2^WIDTH.
  - otherwise cnt holds its value.
  - wrap_q <= 1 only for an increment from 2^WIDTH-1 to 0 or a decrement from 0 to 2^WIDTH-1; otherwise 0. A load never sets wrap_q, including a load of 0 or all-ones.
- Stage 2 (output register) at each rising clk with rst=0:
  - bin_out <= cnt.
  - gray_out <= cnt ^ (cnt >> 1), an unsigned logical shift, so gray_out[WIDTH-1] = cnt[WIDTH-1].
  - tc <= wrap_q.
  - out_valid <= 1.
- Latency: a control sampled on edge k reaches gray_out/bin_out on edge k+1. Total latency is 2 edges from presenting inputs, matching the registered-in/registered-out timing of the decode path.
- out_valid: goes high on the first rising edge after rst deasserts, then stays high until the next reset.
- Gray property: between consecutive step-only updates, gray_out changes in exactly one bit; a hold changes none. A load may change any number of bits.
- No combinational path from any input to any output.

Test Plan:
- Reset and release (WIDTH=4): assert rst mid-count at cnt=5 → gray_out=0000, bin_out=0000, tc=0, out_valid=0 immediately. Release rst → out_valid=1 after the first edge, gray_out=0000.
- Full up-count from 0 with cnt_en=1, up=1 for 16 cycles → gray_out sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000 with tc=1 for exactly that cycle. Check each transition differs in one bit.
- Down-count wrap: load bin_in=1, then cnt_en=1, up=0 → gray_out 0001, 0000, then 1000 (bin_out=1111) with tc=1. tc=0 on all other cycles.
- Load vs step priority: load=1, bin_in=1010, cnt_en=1, up=1 on the same edge → next edge gray_out=1111, bin_out=1010 (no increment), tc=0. Repeat with bin_in=0000 from cnt=15 → tc=0.
- Hold: cnt_en=0, load=0 for 5 cycles at bin_out=0110 → gray_out stays 0101, tc=0.
- Loop-back: drive gray_out into the Gray-to-binary decoder, run random load/step/dir for 1000 cycles → decoded value equals bin_out delayed by the decoder latency (2 cycles) on every cycle.

Source files
------------

// File: rtl/bin_to_gray_counter.sv
// Loadable up/down binary counter feeding a registered Gray-code output stage.
// Latency: controls sampled on edge k appear on gray_out/bin_out at edge k+1; no backpressure.
module bin_to_gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             load,
    input  logic             cnt_en,
    input  logic             up,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] bin_q;
    logic             tc_q;
    logic             valid_q;

    // Load wins over a step; only a genuine roll-over (never a load) flags wrap.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = bin_in;
        end else if (cnt_en) begin
            if (up) begin
                cnt_d  = cnt_q + ONE;
                wrap_d = (cnt_q == ALL_ONES);
            end else begin
                cnt_d  = cnt_q - ONE;
                wrap_d = (cnt_q == '0);
            end
        end
    end

    assign gray_d = cnt_q ^ (cnt_q >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            gray_q  <= '0;
            bin_q   <= '0;
            tc_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            gray_q  <= gray_d;
            bin_q   <= cnt_q;
            tc_q    <= wrap_q;
            valid_q <= 1'b1;
        end
    end

    assign gray_out  = gray_q;
    assign bin_out   = bin_q;
    assign tc        = tc_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Bench for bin_to_gray_counter: arithmetic reference model, per-cycle compare,
// directed literal checks and a Gray-to-binary loop-back decoder.
module tb_bin_to_gray_counter;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] bin_in = '0;
    logic         load = 1'b0;
    logic         cnt_en = 1'b0;
    logic         up = 1'b0;
    logic [W-1:0] gray_out, bin_out;
    logic         out_valid, tc;

    int n_vec = 0;
    int n_err = 0;

    bin_to_gray_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .load(load), .cnt_en(cnt_en), .up(up),
        .gray_out(gray_out), .bin_out(bin_out), .out_valid(out_valid), .tc(tc)
    );

    always #5 clk = ~clk;

    // Reference model as plain integer arithmetic modulo 2^W.
    int m_cnt, m_bin, m_gray, h1, h2;
    bit m_wrap, m_tc, m_valid;

    function automatic int gray_of(input int n);
        return n ^ (n / 2);
    endfunction

    function automatic int next_cnt(input int c, input bit ld, input int b, input bit en, input bit u);
        if (ld)      return b;
        else if (!en) return c;
        else if (u)  return (c + 1) % N;
        else         return (c + N - 1) % N;
    endfunction

    function automatic bit next_wrap(input int c, input bit ld, input bit en, input bit u);
        if (ld || !en) return 1'b0;
        return u ? (c == N - 1) : (c == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; m_wrap <= 0; m_bin <= 0; m_gray <= 0;
            m_tc <= 0; m_valid <= 0; h1 <= 0; h2 <= 0;
        end else begin
            m_bin   <= m_cnt;
            m_gray  <= gray_of(m_cnt);
            m_tc    <= m_wrap;
            m_valid <= 1'b1;
            h1      <= m_bin;
            h2      <= h1;
            m_cnt   <= next_cnt(m_cnt, load, int'(bin_in), cnt_en, up);
            m_wrap  <= next_wrap(m_cnt, load, cnt_en, up);
        end
    end

    // Two-stage registered Gray-to-binary decoder for loop-back.
    function automatic logic [W-1:0] gray_decode(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [W-1:0] dec1_q, dec2_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dec1_q <= '0;
            dec2_q <= '0;
        end else begin
            dec1_q <= gray_out;
            dec2_q <= gray_decode(dec1_q);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        n_vec++;
        if (int'(gray_out) != m_gray || int'(bin_out) != m_bin || tc != m_tc || out_valid != m_valid) begin
            n_err++;
            $display("FAIL cycle t=%0t: gray=%b bin=%b tc=%b vld=%b, model gray=%0d bin=%0d tc=%b vld=%b",
                     $time, gray_out, bin_out, tc, out_valid, m_gray, m_bin, m_tc, m_valid);
        end
        n_vec++;
        if (int'(dec2_q) != h2) begin
            n_err++;
            $display("FAIL loopback t=%0t: decoded=%0d expected=%0d", $time, dec2_q, h2);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input bit ld, input int b, input bit en, input bit u);
        load = ld; bin_in = W'(b); cnt_en = en; up = u;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [W-1:0] up_seq [16];
    logic [W-1:0] prev_g;

    initial begin
        up_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                   4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_gray", int'(gray_out), 0);
        check("reset_valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // Mid-count reset at cnt=5.
        tick(1, 4, 0, 0);
        tick(0, 0, 1, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_gray", int'(gray_out), 0);
        check("midrst_bin", int'(bin_out), 0);
        check("midrst_tc", int'(tc), 0);
        check("midrst_valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(0, 0, 0, 0);
        check("release_valid", int'(out_valid), 1);
        check("release_gray", int'(gray_out), 0);

        // Full up-count with wrap.
        prev_g = gray_out;
        for (int j = 1; j <= 17; j++) begin
            tick(0, 0, 1, 1);
            check($sformatf("upseq_%0d", j), int'(gray_out), int'(up_seq[(j - 1) % 16]));
            check($sformatf("up_tc_%0d", j), int'(tc), (j == 17) ? 1 : 0);
            if (j >= 2) check($sformatf("onebit_%0d", j), $countones(prev_g ^ gray_out), 1);
            prev_g = gray_out;
        end
        tick(0, 0, 0, 0);
        check("up_tc_after", int'(tc), 0);

        // Down-count wrap.
        tick(1, 1, 0, 0);
        tick(0, 0, 1, 0);
        check("dn_g1", int'(gray_out), 4'b0001);
        check("dn_tc1", int'(tc), 0);
        tick(0, 0, 1, 0);
        check("dn_g0", int'(gray_out), 4'b0000);
        check("dn_tc0", int'(tc), 0);
        tick(0, 0, 0, 0);
        check("dn_gwrap", int'(gray_out), 4'b1000);
        check("dn_bwrap", int'(bin_out), 4'b1111);
        check("dn_tcwrap", int'(tc), 1);
        tick(0, 0, 0, 0);
        check("dn_tc_after", int'(tc), 0);

        // Load beats step; loads of 0 never pulse tc.
        tick(1, 4'b1010, 1, 1);
        tick(0, 0, 0, 0);
        check("ldpri_gray", int'(gray_out), 4'b1111);
        check("ldpri_bin", int'(bin_out), 4'b1010);
        check("ldpri_tc", int'(tc), 0);
        tick(1, 15, 0, 0);
        tick(1, 0, 1, 1);
        tick(0, 0, 0, 0);
        check("ld0_bin", int'(bin_out), 0);
        check("ld0_tc", int'(tc), 0);
        tick(0, 0, 0, 0);
        check("ld0_tc2", int'(tc), 0);

        // Hold.
        tick(1, 4'b0110, 0, 0);
        for (int j = 0; j < 5; j++) begin
            tick(0, 0, 0, 1);
            check($sformatf("hold_gray_%0d", j), int'(gray_out), 4'b0101);
            check($sformatf("hold_tc_%0d", j), int'(tc), 0);
        end

        // Random load/step/direction; the per-cycle compare covers model and loop-back.
        for (int j = 0; j < 1000; j++) begin
            tick($urandom_range(7) == 0, int'($urandom_range(N - 1)),
                 $urandom_range(3) != 0, $urandom_range(1) == 1);
        end
        tick(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
